// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 captures the command (operands, mode enables, opcodes).
//   Stage 2 computes the result from the stage-1 registers and registers
//   C/err/ovf/out_valid. Results either wrap or saturate (SATURATE) when they
//   leave the OUTPUT_WIDTH signed range. err_cnt counts delivered error
//   results and sticks at all-ones.
//
// Parameters
//   DATA_WIDTH    operand width (two's complement)
//   OUTPUT_WIDTH  result width, >= DATA_WIDTH
//   SATURATE      1 = clamp on overflow, 0 = keep low OUTPUT_WIDTH bits
//   ERR_CNT_W     error counter width
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready   command handshake (in_ready is combinational)
//   a_en, b_en           mode select
//   a_op, b_op           opcodes for A-mode / B-mode and combined mode
//   A, B                 signed operands
//   out_valid, out_ready result handshake
//   C                    signed result
//   err, ovf             invalid-command flag, overflow flag
//   err_cnt              saturating count of delivered error results
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int DATA_WIDTH   = 5,
    parameter int OUTPUT_WIDTH = DATA_WIDTH + 1,
    parameter bit SATURATE     = 1'b0,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           a_en,
    input  logic                           b_en,
    input  logic [2:0]                     a_op,
    input  logic [1:0]                     b_op,
    input  logic signed [DATA_WIDTH-1:0]   A,
    input  logic signed [DATA_WIDTH-1:0]   B,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUTPUT_WIDTH-1:0] C,
    output logic                           err,
    output logic                           ovf,
    output logic [ERR_CNT_W-1:0]           err_cnt
);

    // Exact-arithmetic width: wide enough for any add/sub of two operands and
    // for the output range limits, so range checks never truncate.
    localparam int XW = (OUTPUT_WIDTH > DATA_WIDTH + 2) ? OUTPUT_WIDTH : DATA_WIDTH + 2;

    localparam logic signed [XW-1:0] OUT_MAX = {{(XW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] OUT_MIN = {{(XW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
    localparam logic signed [XW-1:0] ONE     = XW'(1);
    localparam logic signed [XW-1:0] TWO     = XW'(2);

    localparam logic signed [OUTPUT_WIDTH-1:0] C_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] C_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_B    = 2'b01,
        MODE_A    = 2'b10,
        MODE_AB   = 2'b11
    } mode_e;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // ------------------------------------------------------------------
    // Stage 1: command capture
    // ------------------------------------------------------------------
    mode_e                         s1_mode;
    logic [2:0]                    s1_a_op;
    logic [1:0]                    s1_b_op;
    logic signed [DATA_WIDTH-1:0]  s1_a;
    logic signed [DATA_WIDTH-1:0]  s1_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the payload registers are deliberately left without reset;
    // s1_valid qualifies them, so their power-up contents never escape.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_mode <= mode_e'({a_en, b_en});
            s1_a_op <= a_op;
            s1_b_op <= b_op;
            s1_a    <= A;
            s1_b    <= B;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational compute
    // ------------------------------------------------------------------
    logic signed [XW-1:0]           ax, bx, exact;
    logic [DATA_WIDTH-1:0]          bw;
    logic                           use_bw;
    logic                           inv;
    logic                           ovf_c;
    logic signed [OUTPUT_WIDTH-1:0] c_c;

    assign ax = {{(XW-DATA_WIDTH){s1_a[DATA_WIDTH-1]}}, s1_a};
    assign bx = {{(XW-DATA_WIDTH){s1_b[DATA_WIDTH-1]}}, s1_b};

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave a latch behind.
    always_comb begin
        exact  = '0;
        bw     = '0;
        use_bw = 1'b0;
        inv    = 1'b0;
        ovf_c  = 1'b0;
        c_c    = '0;

        case (s1_mode)
            MODE_A: begin
                case (s1_a_op)
                    3'd0:       exact = ax + bx;
                    3'd1:       exact = ax - bx;
                    3'd2:       begin bw = s1_a ^ s1_b;    use_bw = 1'b1; end
                    3'd3, 3'd4: begin bw = s1_a & s1_b;    use_bw = 1'b1; end
                    3'd5:       begin bw = s1_a | s1_b;    use_bw = 1'b1; end
                    3'd6:       begin bw = ~(s1_a ^ s1_b); use_bw = 1'b1; end
                    default:    inv = 1'b1;
                endcase
            end
            MODE_B: begin
                case (s1_b_op)
                    2'd0:       begin bw = ~(s1_a & s1_b); use_bw = 1'b1; end
                    2'd1, 2'd2: exact = ax + bx;
                    default:    inv = 1'b1;
                endcase
            end
            MODE_AB: begin
                case (s1_b_op)
                    2'd0:    begin bw = s1_a ^ s1_b;    use_bw = 1'b1; end
                    2'd1:    begin bw = ~(s1_a ^ s1_b); use_bw = 1'b1; end
                    2'd2:    exact = ax - ONE;
                    default: exact = bx + TWO;
                endcase
            end
            default: inv = 1'b1;
        endcase

        // Bitwise results are DATA_WIDTH values, sign-extended like operands.
        if (use_bw) begin
            exact = {{(XW-DATA_WIDTH){bw[DATA_WIDTH-1]}}, bw};
        end

        if (inv) begin
            c_c = '0;
        end else begin
            ovf_c = (exact > OUT_MAX) || (exact < OUT_MIN);
            if (ovf_c && SATURATE) begin
                c_c = exact[XW-1] ? C_MIN : C_MAX;
            end else begin
                c_c = exact[OUTPUT_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 output registers; held while the consumer stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            C         <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                C   <= c_c;
                err <= inv;
                ovf <= ovf_c;
            end
        end
    end

    // Counts errored results at the moment they are handed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
